// File: rtl/series_ctrl.sv
// Control FSM sequencing a series-term datapath and accumulator for exp/sin/cos/sinh/cosh/ln(1+x).
// Optional early exit on negligible term: define SERIES_CTRL_EARLY_EXIT_EN.
module series_ctrl #(
  parameter int TERMS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             abort,
  input  logic             done,
  input  logic             term_zero,
  output logic             ready,
  output logic             init_one,
  output logic             init_zero,
  output logic             step,
  output logic             ld_acc,
  output logic             sub,
  output logic [CNT_W-1:0] term_idx,
  output logic             valid,
  output logic             mode_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STEP,
    S_WAIT,
    S_ACC,
    S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(TERMS - 1);

  state_t           state, state_nxt;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] k_q, k_nxt;
  logic             err_q;
  logic             exit_now;
  logic             accept;

  function automatic logic mode_legal(input logic [2:0] m);
    return m <= 3'd5;
  endfunction

  // exp/ln take every term, sin/sinh odd powers, cos/cosh even powers
  function automatic logic term_sel(input logic [2:0] m, input logic [1:0] kl);
    case (m)
      3'd1, 3'd3: return kl[0];
      3'd2, 3'd4: return ~kl[0];
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic term_sub(input logic [2:0] m, input logic [1:0] kl);
    case (m)
      3'd1, 3'd2: return kl[1];
      3'd5:       return ~kl[0];
      default:    return 1'b0;
    endcase
  endfunction

`ifdef SERIES_CTRL_EARLY_EXIT_EN
  assign exit_now = term_zero;
`else
  logic unused_term_zero;
  assign unused_term_zero = term_zero;
  assign exit_now = 1'b0;
`endif

  assign accept = (state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      k_q    <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      k_q   <= k_nxt;
      err_q <= accept && !mode_legal(mode);
      if (accept && mode_legal(mode)) mode_q <= mode;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k_q;
    case (state)
      S_IDLE: if (start && mode_legal(mode)) state_nxt = S_INIT;
      S_INIT: begin
        k_nxt     = CNT_W'(1);
        state_nxt = S_STEP;
      end
      S_STEP: state_nxt = S_WAIT;
      S_WAIT: if (done) state_nxt = S_ACC;
      S_ACC: begin
        if ((k_q == K_LAST) || exit_now) begin
          state_nxt = S_FIN;
        end else begin
          k_nxt     = k_q + CNT_W'(1);
          state_nxt = S_STEP;
        end
      end
      S_FIN: begin
        k_nxt     = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        k_nxt     = '0;
        state_nxt = S_IDLE;
      end
    endcase
    // abort wins over done and every normal transition
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      k_nxt     = '0;
    end
  end

  always_comb begin
    ready     = (state == S_IDLE);
    init_one  = 1'b0;
    init_zero = 1'b0;
    if (state == S_INIT) begin
      init_one  = (mode_q == 3'd0) || (mode_q == 3'd2) || (mode_q == 3'd4);
      init_zero = !init_one;
    end
    step     = (state == S_STEP);
    ld_acc   = (state == S_ACC) && !abort && term_sel(mode_q, k_q[1:0]);
    sub      = ld_acc && term_sub(mode_q, k_q[1:0]);
    valid    = (state == S_FIN) && !abort;
    term_idx = k_q;
    mode_err = err_q;
  end

endmodule

// File: tb/tb_series_ctrl.sv
// Bench for series_ctrl: per-cycle expected output trace built from the series rules, plus literal pins.
module tb_series_ctrl;
  localparam int TERMS = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort, done, term_zero;
  logic [2:0]       mode;
  logic             ready, init_one, init_zero, step, ld_acc, sub, valid, mode_err;
  logic [CNT_W-1:0] term_idx;

  always #5 clk = ~clk;

  series_ctrl #(.TERMS(TERMS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .done(done),
    .term_zero(term_zero), .ready(ready), .init_one(init_one), .init_zero(init_zero),
    .step(step), .ld_acc(ld_acc), .sub(sub), .term_idx(term_idx), .valid(valid),
    .mode_err(mode_err)
  );

  typedef struct {
    logic rst_n, start, abort, done, tz;
    logic [2:0] mode;
    logic e_rdy, e_i1, e_i0, e_step, e_ld, e_sub, e_val, e_err;
    logic [CNT_W-1:0] ek;
    int tag;
  } cyc_t;

  cyc_t tr[$];
  int   abort_at = -1, rst_at = -1, tz_k = -1, cur_tag = 0;
  bit   quiet = 1'b1;
  int   n_cmp = 0, n_fail = 0;

  function automatic bit sel(input int m, input int k);
    if (m == 1 || m == 3) return (k % 2) == 1;
    if (m == 2 || m == 4) return (k % 2) == 0;
    return 1'b1;
  endfunction

  function automatic bit subb(input int m, input int k);
    if (m == 1 || m == 2) return ((k / 2) % 2) == 1;
    if (m == 5) return (k % 2) == 0;
    return 1'b0;
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c.rst_n = 1'b1; c.start = 1'b0; c.abort = 1'b0;
    c.done  = quiet ? 1'b0 : 1'($urandom_range(0, 1));
    c.tz    = quiet ? 1'b0 : ($urandom_range(0, 5) == 0);
    c.mode  = quiet ? 3'd0 : 3'($urandom_range(0, 7));
    if (!quiet) c.start = 1'($urandom_range(0, 1));
    c.e_rdy = 0; c.e_i1 = 0; c.e_i0 = 0; c.e_step = 0;
    c.e_ld = 0; c.e_sub = 0; c.e_val = 0; c.e_err = 0;
    c.ek = '0; c.tag = cur_tag;
    return c;
  endfunction

  task automatic push_idle(input bit st, input logic [2:0] m, input bit err);
    cyc_t c;
    c = blank();
    c.start = st;
    if (st) c.mode = m;
    else if (!quiet) c.abort = ($urandom_range(0, 7) == 0);
    c.e_rdy = 1'b1;
    c.e_err = err;
    tr.push_back(c);
  endtask

  task automatic emit(input cyc_t c, input int n, output bit stop);
    stop = 1'b0;
    if (n == abort_at) begin
      c.abort = 1'b1; c.e_ld = 1'b0; c.e_sub = 1'b0; c.e_val = 1'b0;
      stop = 1'b1;
    end else if (n == rst_at) begin
      c.rst_n = 1'b0;
      stop = 1'b1;
    end
    tr.push_back(c);
  endtask

  // One evaluation: start cycle, INIT, per-term STEP/WAIT*D/ACC, FIN.
  task automatic run(input int m, input int dmax);
    cyc_t c;
    int   n, kl, d;
    bit   stop;
    push_idle(1'b1, 3'(m), 1'b0);
    n = 0;
    kl = 0;
    c = blank();
    c.e_i1 = (m == 0 || m == 2 || m == 4);
    c.e_i0 = !c.e_i1;
    emit(c, n, stop); n++;
    if (stop) return;
    for (int k = 1; k < TERMS; k++) begin
      kl = k;
      d = $urandom_range(1, dmax);
      c = blank(); c.e_step = 1'b1; c.ek = CNT_W'(k);
      emit(c, n, stop); n++;
      if (stop) return;
      for (int w = 1; w <= d; w++) begin
        c = blank(); c.done = (w == d); c.ek = CNT_W'(k);
        emit(c, n, stop); n++;
        if (stop) return;
      end
      c = blank(); c.ek = CNT_W'(k);
      if (k == tz_k) c.tz = 1'b1;
      c.e_ld  = sel(m, k);
      c.e_sub = c.e_ld && subb(m, k);
      emit(c, n, stop); n++;
      if (stop) return;
`ifdef SERIES_CTRL_EARLY_EXIT_EN
      if (c.tz) break;
`endif
    end
    c = blank(); c.e_val = 1'b1; c.ek = CNT_W'(kl);
    emit(c, n, stop);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    cyc_t c;
    logic [15:0] act, exp;
    int ld_k[$], ld_s[$];
    int v2 = 0, err3 = 0, init3 = 0, ld4 = 0, v4 = 0;

    // reset held two cycles with start high
    for (int i = 0; i < 2; i++) begin
      c = blank(); c.rst_n = 1'b0; c.start = 1'b1; c.e_rdy = 1'b1;
      tr.push_back(c);
    end
    push_idle(1'b0, 3'd0, 1'b0);
    cur_tag = 1; run(1, 1); cur_tag = 0;
    push_idle(1'b0, 3'd0, 1'b0);
    cur_tag = 2; abort_at = 8; run(1, 1); abort_at = -1; cur_tag = 0;
    run(2, 1);
    push_idle(1'b0, 3'd0, 1'b0);
    cur_tag = 3;
    push_idle(1'b1, 3'd6, 1'b0);
    push_idle(1'b0, 3'd0, 1'b1);
    push_idle(1'b0, 3'd0, 1'b0);
    cur_tag = 4; tz_k = 4; run(0, 1); tz_k = -1; cur_tag = 0;
    run(5, 2);
    quiet = 1'b0;
    for (int r = 0; r < 60; r++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) push_idle(1'b0, 3'd0, 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        push_idle(1'b1, 3'($urandom_range(6, 7)), 1'b0);
        push_idle(1'b0, 3'd0, 1'b1);
      end
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : -1;
      rst_at   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 30) : -1;
      run($urandom_range(0, 5), 4);
    end
    abort_at = -1; rst_at = -1; quiet = 1'b1;
    push_idle(1'b0, 3'd0, 1'b0);
    push_idle(1'b0, 3'd0, 1'b0);

    rst = 1'b0; start = 1'b1; mode = 3'd0; abort = 1'b0; done = 1'b0; term_zero = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < tr.size(); i++) begin
      rst = tr[i].rst_n; start = tr[i].start; mode = tr[i].mode;
      abort = tr[i].abort; done = tr[i].done; term_zero = tr[i].tz;
      @(negedge clk);
      act = {4'd0, ready, init_one, init_zero, step, ld_acc, sub, valid, mode_err, term_idx};
      exp = {4'd0, tr[i].e_rdy, tr[i].e_i1, tr[i].e_i0, tr[i].e_step, tr[i].e_ld,
             tr[i].e_sub, tr[i].e_val, tr[i].e_err, tr[i].ek};
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d {rdy,i1,i0,step,ld,sub,val,err,k}: got %h expected %h",
                 i, act, exp);
      end
      case (tr[i].tag)
        1: if (ld_acc) begin ld_k.push_back(int'(term_idx)); ld_s.push_back(int'(sub)); end
        2: v2 += int'(valid);
        3: begin err3 += int'(mode_err); init3 += int'(init_one) + int'(init_zero); end
        4: begin ld4 += int'(ld_acc); v4 += int'(valid); end
        default: ;
      endcase
      @(posedge clk); #1;
    end

    chk("sin_ld_count", ld_k.size(), 4);
    for (int j = 0; j < ld_k.size() && j < 4; j++) begin
      chk("sin_ld_k", ld_k[j], 2 * j + 1);
      chk("sin_sub", ld_s[j], j % 2);
    end
    chk("abort_valid_count", v2, 0);
    chk("illegal_mode_err_count", err3, 1);
    chk("illegal_init_count", init3, 0);
`ifdef SERIES_CTRL_EARLY_EXIT_EN
    chk("exp_tz_ld_count", ld4, 4);
`else
    chk("exp_tz_ld_count", ld4, TERMS - 1);
`endif
    chk("exp_tz_valid_count", v4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/series_ctrl.md
# series_ctrl

Parametrised control FSM for Taylor/Maclaurin series evaluation in the sin/cos/exp/ln math-function units. It sequences a term datapath (multiply/divide unit with `done` handshake) and an accumulator. Per mode, it selects which terms are accumulated and whether each is added or subtracted. It replaces per-function controllers with one block that owns the term counter, runs a configurable number of terms and adds hyperbolic, log, abort and early-exit support.

## Interface
Parameters:
- `TERMS`, 8: number of series term indices evaluated, 0..TERMS-1; legal 2..2^CNT_W-1.
- `CNT_W`, 4: width of the term counter / `term_idx`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  3  0 exp, 1 sin, 2 cos, 3 sinh, 4 cosh, 5 ln(1+x); 6/7 illegal.
- `abort`  in  1  cancel current evaluation.
- `done`  in  1  datapath term-ready pulse; sampled only in WAIT.
- `term_zero`  in  1  datapath: current term magnitude below LSB (see Configuration).
- `ready`  out  1  idle, accepting `start`.
- `init_one`  out  1  acc <= 1, term <= 1 (exp, cos, cosh).
- `init_zero`  out  1  acc <= 0, term <= 1 (sin, sinh, ln).
- `step`  out  1  one-cycle command: compute term `term_idx` from previous term.
- `ld_acc`  out  1  accumulator load enable for current term.
- `sub`  out  1  with `ld_acc`: 1 = acc - term, 0 = acc + term.
- `term_idx`  out  CNT_W  current term index k.
- `valid`  out  1  one-cycle result-valid pulse.
- `mode_err`  out  1  one-cycle pulse: start with illegal mode.

## Operation
- States: IDLE, INIT, STEP, WAIT, ACC, FIN.
- IDLE: `ready`=1. `start`=1 and legal mode -> INIT, `mode` latched; illegal mode -> `mode_err`=1 next cycle, stay IDLE.
- INIT: assert `init_one` or `init_zero` per latched mode, set k=1 -> STEP.
- STEP: `step`=1 -> WAIT.
- WAIT: hold until `done`=1 -> ACC.
- ACC: term selection: exp/ln all k; sin/sinh odd k; cos/cosh even k. `ld_acc`=1 if selected. `sub`: sin/cos = k[1]; ln = ~k[0]; exp/sinh/cosh = 0. If k==TERMS-1 -> FIN, else k<=k+1 -> STEP.
- FIN: `valid`=1 -> IDLE.
- Unselected terms are still computed (`step`/`done` run), since the term recurrence needs every power.
- `abort`=1 in any non-IDLE state: next state IDLE, no `valid`, no `ld_acc` that cycle; k cleared.
- `start` and latched mode are ignored outside IDLE; `mode` changes mid-run have no effect.
- `done` outside WAIT is ignored, including `done` coincident with `step`.
- All outputs are decoded from state, latched mode and k; no output depends combinationally on `start`/`done` except `ld_acc`/`sub` (state+k only).

## Timing
- Reset: on clock edge with `rst`=0 -> IDLE, k=0, mode=0. Outputs then: `ready`=1; all others 0; `term_idx`=0. Reset mid-run discards the run with no `valid`.
- `start` to INIT: 1 cycle. INIT to first `step`: 1 cycle.
- Per term: STEP 1 + WAIT D (D>=1, cycles up to and including `done`) + ACC 1.
- Total `start`-edge to `valid`: 2 + (TERMS-1)(2+D) + 1 cycles; `ready` returns the cycle after `valid`.
- Back-to-back: `start` held high re-triggers immediately from IDLE after FIN.
- Abort priority: `abort` > `done` > normal transitions; `rst` over all.

## Configuration
- `SERIES_CTRL_EARLY_EXIT_EN` defined: in ACC, `term_zero`=1 -> FIN regardless of k. The current term's `ld_acc` is still applied. `valid` comes early.
- Not defined: `term_zero` ignored; always TERMS-1 terms.

## Test plan
- Reset: hold `rst`=0 2 cycles with `start`=1 -> `ready`=1, all other outputs 0, `term_idx`=0; no INIT.
- sin, TERMS=8, D=1: `ld_acc` at k=1,3,5,7 with `sub`=0,1,0,1. `valid` 3+7·3=24 cycles after the start edge.
- cos/ln, TERMS=6: cos `init_one`, `ld_acc` k=2,4 with `sub`=1,0. ln `init_zero`, `ld_acc` k=1..5 with `sub`=0,1,0,1,0.
- Abort at WAIT of k=3 together with `done` -> IDLE next cycle, no `ld_acc`, no `valid`. New start then begins at k=1.
- mode=6 with `start` -> one `mode_err` pulse, `ready` stays 1, no `init_*`.
- EARLY_EXIT on, exp, `term_zero`=1 at ACC k=4 -> `ld_acc`=1 at k=4, FIN next, `valid`. Macro off: run continues to k=TERMS-1.
